// File: rtl/pwr_supervisor_if.sv
// pwr_supervisor_if: groups the sequencer-facing signals of pwr_supervisor.
//   stage_en    [3:0] stage enables from the sequencer (bit i = stage i)
//   stage_pg    [3:0] synchronised per-stage power-good (bit 0 tied high)
//   fault_clear       single-cycle clear request, honoured only in FAULT
//   stage_kill  [3:0] force stage i off (rail EN = stage_en & ~stage_kill)
//   fpga_prog_b       target PROGRAM_B, active-low
//   power_ok          all rails good and target released
//   fault             shutdown in progress or latched
//   fault_stage [1:0] lowest-index stage with PG low at detection
// slave = the supervisor, master = the sequencer side / bench.
interface pwr_supervisor_if;
  logic [3:0] stage_en;
  logic [3:0] stage_pg;
  logic       fault_clear;
  logic [3:0] stage_kill;
  logic       fpga_prog_b;
  logic       power_ok;
  logic       fault;
  logic [1:0] fault_stage;

  modport slave (
    input  stage_en, stage_pg, fault_clear,
    output stage_kill, fpga_prog_b, power_ok, fault, fault_stage
  );

  modport master (
    output stage_en, stage_pg, fault_clear,
    input  stage_kill, fpga_prog_b, power_ok, fault, fault_stage
  );
endinterface

// File: rtl/pwr_supervisor.sv
// pwr_supervisor: watches the sequencer stage enables and power-goods,
// releases the FPGA PROGRAM_B once all rails have settled, and on a debounced
// PG loss (or power-up timeout) kills the rails in reverse order, then
// latches the fault until fault_clear.
// Ports:
//   clk  free-running clock, single domain
//   rst  synchronous active-high reset
//   bus  pwr_supervisor_if.slave (stage_en/stage_pg/fault_clear in;
//        stage_kill/fpga_prog_b/power_ok/fault/fault_stage out)
// All outputs are registered; they are decoded from the next state so they
// line up with the state register.
module pwr_supervisor #(
  parameter int SETTLE_CYCLES = 16384,
  parameter int PROG_CYCLES   = 64,
  parameter int GLITCH_CYCLES = 4,
  parameter int SHDN_CYCLES   = 16384,
  parameter int UP_TIMEOUT    = 65536
) (
  input logic            clk,
  input logic            rst,
  pwr_supervisor_if.slave bus
);

  localparam int M0   = (SETTLE_CYCLES > PROG_CYCLES) ? SETTLE_CYCLES : PROG_CYCLES;
  localparam int M1   = (GLITCH_CYCLES > SHDN_CYCLES) ? GLITCH_CYCLES : SHDN_CYCLES;
  localparam int M2   = (M0 > M1) ? M0 : M1;
  localparam int MAXP = (M2 > UP_TIMEOUT) ? M2 : UP_TIMEOUT;
  localparam int CW   = $clog2(MAXP) + 1;

  typedef enum logic [2:0] {
    ST_WAIT, ST_SETTLE, ST_PROG, ST_RUN, ST_SHDN, ST_FAULT
  } state_t;

  state_t        state, state_nxt;
  logic [CW-1:0] up_cnt, up_nxt;    // power-up timeout
  logic [CW-1:0] tmr, tmr_nxt;      // settle / prog / shutdown step timer
  logic [CW-1:0] glt, glt_nxt;      // consecutive PG-low samples
  logic [1:0]    step, step_nxt;    // kill steps already taken in SHDN
  logic [3:0]    kill_q, kill_nxt;
  logic [1:0]    fs_q, fs_nxt;
  logic          prog_b_q, pok_q, fault_q;
  logic          all_good, drop;

  function automatic logic [1:0] low_idx(input logic [3:0] pg);
    low_idx = 2'd3;
    for (int i = 3; i >= 0; i--)
      if (!pg[i]) low_idx = 2'(i);
  endfunction

  assign all_good = (bus.stage_en == 4'hF) && (bus.stage_pg == 4'hF);
  // This sample is the GLITCH_CYCLES-th consecutive low one.
  assign drop = (bus.stage_pg != 4'hF) && (glt == CW'(GLITCH_CYCLES - 1));

  always_comb begin
    state_nxt = state;
    up_nxt    = up_cnt;
    tmr_nxt   = tmr;
    glt_nxt   = glt;
    step_nxt  = step;
    kill_nxt  = kill_q;
    fs_nxt    = fs_q;
    unique case (state)
      ST_WAIT: begin
        if (bus.stage_en[0]) up_nxt = up_cnt + 1'b1;
        if (all_good) begin
          state_nxt = ST_SETTLE;
          up_nxt    = '0;
          tmr_nxt   = '0;
          glt_nxt   = '0;
        end else if (up_cnt == CW'(UP_TIMEOUT)) begin
          state_nxt = ST_SHDN;
          up_nxt    = '0;
          tmr_nxt   = '0;
          step_nxt  = '0;
          kill_nxt  = 4'b1000;
          fs_nxt    = low_idx(bus.stage_pg);
        end
      end
      ST_SETTLE, ST_PROG, ST_RUN: begin
        glt_nxt = (bus.stage_pg == 4'hF) ? '0 : glt + 1'b1;
        if (state != ST_RUN) tmr_nxt = tmr + 1'b1;
        // Drop detection outranks the phase advance on the same edge.
        if (drop) begin
          state_nxt = ST_SHDN;
          tmr_nxt   = '0;
          glt_nxt   = '0;
          step_nxt  = '0;
          kill_nxt  = 4'b1000;
          fs_nxt    = low_idx(bus.stage_pg);
        end else if (state == ST_SETTLE && tmr == CW'(SETTLE_CYCLES - 1)) begin
          state_nxt = ST_PROG;
          tmr_nxt   = '0;
        end else if (state == ST_PROG && tmr == CW'(PROG_CYCLES - 1)) begin
          state_nxt = ST_RUN;
          tmr_nxt   = '0;
        end
      end
      ST_SHDN: begin
        tmr_nxt = tmr + 1'b1;
        if (tmr == CW'(SHDN_CYCLES - 1)) begin
          tmr_nxt = '0;
          if (step == 2'd3) begin
            state_nxt = ST_FAULT;
          end else begin
            step_nxt = step + 1'b1;
            kill_nxt = {1'b1, kill_q[3:1]};  // next-lower stage goes off
          end
        end
      end
      ST_FAULT: begin
        if (bus.fault_clear) begin
          state_nxt = ST_WAIT;
          up_nxt    = '0;
          tmr_nxt   = '0;
          glt_nxt   = '0;
          step_nxt  = '0;
          kill_nxt  = '0;
          fs_nxt    = '0;
        end
      end
      default: state_nxt = ST_WAIT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_WAIT;
      up_cnt   <= '0;
      tmr      <= '0;
      glt      <= '0;
      step     <= '0;
      kill_q   <= '0;
      fs_q     <= '0;
      prog_b_q <= 1'b0;
      pok_q    <= 1'b0;
      fault_q  <= 1'b0;
    end else begin
      state    <= state_nxt;
      up_cnt   <= up_nxt;
      tmr      <= tmr_nxt;
      glt      <= glt_nxt;
      step     <= step_nxt;
      kill_q   <= kill_nxt;
      fs_q     <= fs_nxt;
      prog_b_q <= (state_nxt == ST_RUN);
      pok_q    <= (state_nxt == ST_RUN);
      fault_q  <= (state_nxt == ST_SHDN) || (state_nxt == ST_FAULT);
    end
  end

  assign bus.stage_kill  = kill_q;
  assign bus.fpga_prog_b = prog_b_q;
  assign bus.power_ok    = pok_q;
  assign bus.fault       = fault_q;
  assign bus.fault_stage = fs_q;

endmodule
